// File: rtl/cc_nestgen_pkg.sv
// Shared definitions for the bird-row generator and the nest checker:
// state encoding, row constants and the decoded command bundle.
package cc_nestgen_pkg;

    localparam int NESTGEN_ROW_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RUN_LEFT  = 2'd1;
    localparam logic [1:0] ST_RUN_RIGHT = 2'd2;
    localparam logic [1:0] ST_LANDED    = 2'd3;

    localparam logic [NESTGEN_ROW_W-1:0] START_ROW = 8'b0001_0000;
    localparam logic [NESTGEN_ROW_W-1:0] NEST_R    = 8'b0010_0000;
    localparam logic [NESTGEN_ROW_W-1:0] NEST_L    = 8'b0000_0100;

    // Player commands after conversion from active-low pins to active-high flags.
    typedef struct packed {
        logic start;
        logic left;
        logic right;
        logic drop;
    } cmd_t;

endpackage

// File: rtl/cc_nestgen_prescaler.sv
// Step prescaler: counts while enabled, ticks on TICKMAX-1 and wraps to zero.
module cc_nestgen_prescaler
    import cc_nestgen_pkg::*;
#(
    parameter int TICKWIDTH = 26,
    parameter int TICKMAX   = 25000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [TICKWIDTH-1:0] LAST = TICKWIDTH'(TICKMAX - 1);

    logic [TICKWIDTH-1:0] count_q;
    logic [TICKWIDTH-1:0] count_d;

    // Tick does not depend on clr_i, so the top can use it while deciding clr_i.
    assign tick_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tick_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cc_nestgen.sv
// Bird-row generator: a one-hot bit bounces across the row at the prescaled
// step rate; a drop either lands it on a nest or reports a one-cycle miss.
module cc_nestgen
    import cc_nestgen_pkg::*;
#(
    parameter int NESTGEN_DATAWIDTH = 8,
    parameter int NESTGEN_TICKWIDTH = 26,
    parameter int NESTGEN_TICKMAX   = 25000000
) (
    input  logic                         CC_NESTGEN_CLOCK_50,
    input  logic                         CC_NESTGEN_RESET_InLow,
    input  logic                         CC_NESTGEN_start_InLow,
    input  logic                         CC_NESTGEN_left_InLow,
    input  logic                         CC_NESTGEN_right_InLow,
    input  logic                         CC_NESTGEN_drop_InLow,
    output logic [NESTGEN_DATAWIDTH-1:0] CC_NESTGEN_data_OutBUS,
    output logic                         CC_NESTGEN_running_OutLow,
    output logic                         CC_NESTGEN_landed_OutLow,
    output logic                         CC_NESTGEN_miss_OutLow
);

    localparam int MSB = NESTGEN_DATAWIDTH - 1;
    localparam logic [NESTGEN_DATAWIDTH-1:0] START_W  = NESTGEN_DATAWIDTH'(START_ROW);
    localparam logic [NESTGEN_DATAWIDTH-1:0] NEST_R_W = NESTGEN_DATAWIDTH'(NEST_R);
    localparam logic [NESTGEN_DATAWIDTH-1:0] NEST_L_W = NESTGEN_DATAWIDTH'(NEST_L);

    logic [1:0]                   state_q, state_d;
    logic [NESTGEN_DATAWIDTH-1:0] data_q, data_d;
    logic                         running_n_q, running_n_d;
    logic                         landed_n_q, landed_n_d;
    logic                         miss_n_q, miss_n_d;
    logic [1:0]                   dir;
    logic                         is_run;
    logic                         on_nest;
    logic                         tick;
    logic                         pre_clr;
    cmd_t                         cmd;

    assign cmd.start = ~CC_NESTGEN_start_InLow;
    assign cmd.left  = ~CC_NESTGEN_left_InLow;
    assign cmd.right = ~CC_NESTGEN_right_InLow;
    assign cmd.drop  = ~CC_NESTGEN_drop_InLow;

    assign is_run  = (state_q == ST_RUN_LEFT) || (state_q == ST_RUN_RIGHT);
    assign on_nest = (data_q == NEST_R_W) || (data_q == NEST_L_W);
    // Counter only runs while flying; any drop restarts it from zero.
    assign pre_clr = !is_run || cmd.drop;

    cc_nestgen_prescaler #(
        .TICKWIDTH (NESTGEN_TICKWIDTH),
        .TICKMAX   (NESTGEN_TICKMAX)
    ) u_prescaler (
        .clk_i   (CC_NESTGEN_CLOCK_50),
        .rst_n_i (CC_NESTGEN_RESET_InLow),
        .clr_i   (pre_clr),
        .en_i    (is_run),
        .tick_o  (tick)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        miss_n_d = 1'b1;
        dir      = state_q;
        case (state_q)
            ST_IDLE, ST_LANDED: begin
                if (cmd.start) begin
                    state_d = ST_RUN_LEFT;
                    data_d  = START_W;
                end
            end
            ST_RUN_LEFT, ST_RUN_RIGHT: begin
                if (cmd.drop) begin
                    if (on_nest) begin
                        state_d = ST_LANDED;
                    end else begin
                        state_d  = ST_IDLE;
                        data_d   = START_W;
                        miss_n_d = 1'b0;
                    end
                end else begin
                    if (tick) begin
                        if (state_q == ST_RUN_LEFT) begin
                            if (data_q[MSB]) begin
                                dir    = ST_RUN_RIGHT;
                                data_d = data_q >> 1;
                            end else begin
                                data_d = data_q << 1;
                            end
                        end else begin
                            if (data_q[0]) begin
                                dir    = ST_RUN_LEFT;
                                data_d = data_q << 1;
                            end else begin
                                data_d = data_q >> 1;
                            end
                        end
                    end
                    // Steering overrides the bounce direction but never moves the bit.
                    if (cmd.left && !cmd.right) begin
                        dir = ST_RUN_LEFT;
                    end else if (cmd.right && !cmd.left) begin
                        dir = ST_RUN_RIGHT;
                    end
                    state_d = dir;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = START_W;
            end
        endcase
    end

    assign running_n_d = !((state_d == ST_RUN_LEFT) || (state_d == ST_RUN_RIGHT));
    assign landed_n_d  = (state_d != ST_LANDED);

    always_ff @(posedge CC_NESTGEN_CLOCK_50 or negedge CC_NESTGEN_RESET_InLow) begin
        if (!CC_NESTGEN_RESET_InLow) begin
            state_q     <= ST_IDLE;
            data_q      <= START_W;
            running_n_q <= 1'b1;
            landed_n_q  <= 1'b1;
            miss_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            running_n_q <= running_n_d;
            landed_n_q  <= landed_n_d;
            miss_n_q    <= miss_n_d;
        end
    end

    assign CC_NESTGEN_data_OutBUS    = data_q;
    assign CC_NESTGEN_running_OutLow = running_n_q;
    assign CC_NESTGEN_landed_OutLow  = landed_n_q;
    assign CC_NESTGEN_miss_OutLow    = miss_n_q;

endmodule

// File: tb/tb_cc_nestgen.sv
// Directed bench for cc_nestgen with a short step period (TICKMAX = 4).
module tb_cc_nestgen;

    logic       clk;
    logic       rst_n;
    logic       start_n, left_n, right_n, drop_n;
    logic [7:0] data;
    logic       running_n, landed_n, miss_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Commands are active-high in the table; expected outputs are pin levels.
    typedef struct {
        bit         start, left, right, drop;
        logic [7:0] exp_data;
        logic       exp_run_n, exp_land_n, exp_miss_n;
    } vec_t;

    vec_t vecs[$];

    cc_nestgen #(
        .NESTGEN_DATAWIDTH (8),
        .NESTGEN_TICKWIDTH (26),
        .NESTGEN_TICKMAX   (4)
    ) dut (
        .CC_NESTGEN_CLOCK_50       (clk),
        .CC_NESTGEN_RESET_InLow    (rst_n),
        .CC_NESTGEN_start_InLow    (start_n),
        .CC_NESTGEN_left_InLow     (left_n),
        .CC_NESTGEN_right_InLow    (right_n),
        .CC_NESTGEN_drop_InLow     (drop_n),
        .CC_NESTGEN_data_OutBUS    (data),
        .CC_NESTGEN_running_OutLow (running_n),
        .CC_NESTGEN_landed_OutLow  (landed_n),
        .CC_NESTGEN_miss_OutLow    (miss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ed, input logic er, input logic el,
                           input logic em);
        chk({tag, "_data"}, data, ed);
        chk({tag, "_run"}, {7'd0, running_n}, {7'd0, er});
        chk({tag, "_land"}, {7'd0, landed_n}, {7'd0, el});
        chk({tag, "_miss"}, {7'd0, miss_n}, {7'd0, em});
    endtask

    task automatic add(input bit s, input bit l, input bit r, input bit d, input logic [7:0] ed,
                       input logic er, input logic el, input logic em);
        vec_t v;
        v.start = s; v.left = l; v.right = r; v.drop = d;
        v.exp_data = ed; v.exp_run_n = er; v.exp_land_n = el; v.exp_miss_n = em;
        vecs.push_back(v);
    endtask

    task automatic rep(input int n, input logic [7:0] ed, input logic er, input logic el);
        for (int k = 0; k < n; k++) add(0, 0, 0, 0, ed, er, el, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit l, input bit r, input bit d);
        start_n = ~s; left_n = ~l; right_n = ~r; drop_n = ~d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        // Basic flight: 0x10 -> 0x20 -> 0x40 -> 0x80 -> bounce 0x40, every 4 clocks.
        add(1, 0, 0, 0, 8'h10, 0, 1, 1); rep(3, 8'h10, 0, 1);
        rep(1, 8'h20, 0, 1); rep(3, 8'h20, 0, 1);
        rep(1, 8'h40, 0, 1); rep(3, 8'h40, 0, 1);
        rep(1, 8'h80, 0, 1); rep(3, 8'h80, 0, 1);
        rep(1, 8'h40, 0, 1);
        // Now RUN_RIGHT: steer left, then both (no change), tick goes left.
        add(0, 1, 0, 0, 8'h40, 0, 1, 1);
        add(0, 1, 1, 0, 8'h40, 0, 1, 1);
        rep(1, 8'h40, 0, 1);
        rep(1, 8'h80, 0, 1);
        add(0, 0, 1, 0, 8'h80, 0, 1, 1); rep(2, 8'h80, 0, 1);
        rep(1, 8'h40, 0, 1); rep(3, 8'h40, 0, 1);
        rep(1, 8'h20, 0, 1);
        // Drop on NEST_R: land and freeze; drop/steer ignored while landed.
        add(0, 0, 0, 1, 8'h20, 1, 0, 1);
        add(0, 1, 0, 1, 8'h20, 1, 0, 1);
        rep(21, 8'h20, 1, 0);
        add(1, 0, 0, 0, 8'h10, 0, 1, 1); rep(3, 8'h10, 0, 1);
        rep(1, 8'h20, 0, 1);
        // RUN_LEFT at 0x20, right steer -> next tick gives 0x10.
        add(0, 0, 1, 0, 8'h20, 0, 1, 1); rep(2, 8'h20, 0, 1);
        rep(1, 8'h10, 0, 1); rep(3, 8'h10, 0, 1);
        rep(1, 8'h08, 0, 1);
        // Drop at 0x08: one-cycle miss pulse, back to IDLE; IDLE ignores drop/steer.
        add(0, 0, 0, 1, 8'h10, 1, 1, 0);
        add(0, 0, 0, 0, 8'h10, 1, 1, 1);
        add(0, 1, 0, 1, 8'h10, 1, 1, 1);
        // Head right to 0x04, then drop + left on the tick cycle.
        add(1, 0, 0, 0, 8'h10, 0, 1, 1);
        add(0, 0, 1, 0, 8'h10, 0, 1, 1); rep(2, 8'h10, 0, 1);
        rep(1, 8'h08, 0, 1); rep(3, 8'h08, 0, 1);
        rep(1, 8'h04, 0, 1); rep(3, 8'h04, 0, 1);
        add(0, 1, 0, 1, 8'h04, 1, 0, 1);
        rep(1, 8'h04, 1, 0);
        // Restart from LANDED; start while running is ignored.
        add(1, 0, 0, 0, 8'h10, 0, 1, 1); rep(3, 8'h10, 0, 1);
        rep(1, 8'h20, 0, 1);
        add(1, 0, 0, 0, 8'h20, 0, 1, 1); rep(2, 8'h20, 0, 1);
        rep(1, 8'h40, 0, 1);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 8'h10, 1, 1, 1);
        rst_n = 1'b1;
        step();
        chk_all("post_release", 8'h10, 1, 1, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].left, vecs[i].right, vecs[i].drop);
            step();
            chk_all($sformatf("row%0d", i), vecs[i].exp_data, vecs[i].exp_run_n,
                    vecs[i].exp_land_n, vecs[i].exp_miss_n);
        end
        drive(0, 0, 0, 0);

        // Asynchronous reset mid-run at 0x40, checked before the next clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h10, 1, 1, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_all("rst_idle", 8'h10, 1, 1, 1);

        // Restart after reset: first shift exactly 4 clocks after the start edge.
        drive(1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        chk_all("restart", 8'h10, 0, 1, 1);
        repeat (3) step();
        chk("restart_hold", data, 8'h10);
        step();
        chk("restart_shift", data, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
